reg_writeback: RTL

Write-side front end of the 16-entry, 16-bit register file. Accepts result writebacks from the ALU and memory stages over valid/ready handshakes, orders them in a small FIFO, and drains one entry per cycle into the register file write port. Because register file writes commit on the clock edge, it also forwards still-pending results to the two read ports.

---
 rtl/reg_writeback_pkg.sv | 15 +
 rtl/reg_writeback_wb_fifo.sv | 83 ++++++++
 rtl/reg_writeback.sv | 113 +++++++++++
 3 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared constants for the register writeback front end: default widths,
// pending-write FIFO depth and the hard-wired zero register index.
package reg_writeback_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int R_ZERO     = 0;

    // Slots available this cycle, counting the head that pops concurrently.
    function automatic int free_slots(input int count, input int depth);
        return depth - count + ((count != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// In-order pending-write FIFO with two ordered pushes and one pop; slot 0 is
// always the oldest entry so every slot is exposed in age order for matching.
module wb_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push0,
    input  logic [ADDR_W-1:0]               push0_reg,
    input  logic [DATA_W-1:0]               push0_data,
    input  logic                            push1,
    input  logic [ADDR_W-1:0]               push1_reg,
    input  logic [DATA_W-1:0]               push1_data,
    input  logic                            pop,
    output logic [ADDR_W-1:0]               head_reg,
    output logic [DATA_W-1:0]               head_data,
    output logic [$clog2(DEPTH):0]          count,
    output logic [DEPTH-1:0]                entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]    entry_reg,
    output logic [DEPTH-1:0][DATA_W-1:0]    entry_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] reg_q, reg_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [CW-1:0]                count_q, count_d;
    logic [CW-1:0]                slot0, slot1;
    logic                         pop_en;

    assign pop_en = pop && (count_q != '0);

    // Shift out the head, then land push0 and push1 in the next free slots.
    always_comb begin
        reg_d  = reg_q;
        data_d = data_q;
        if (pop_en) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                reg_d[i]  = reg_q[i+1];
                data_d[i] = data_q[i+1];
            end
        end
        slot0 = count_q - CW'(pop_en);
        slot1 = slot0 + CW'(push0);
        if (push0 && (slot0 < CW'(DEPTH))) begin
            reg_d[slot0[IW-1:0]]  = push0_reg;
            data_d[slot0[IW-1:0]] = push0_data;
        end
        if (push1 && (slot1 < CW'(DEPTH))) begin
            reg_d[slot1[IW-1:0]]  = push1_reg;
            data_d[slot1[IW-1:0]] = push1_data;
        end
        count_d = count_q - CW'(pop_en) + CW'(push0) + CW'(push1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            reg_q   <= reg_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = (CW'(i) < count_q);
        end
    end

    assign entry_reg  = reg_q;
    assign entry_data = data_q;
    assign head_reg   = reg_q[0];
    assign head_data  = data_q[0];
    assign count      = count_q;

endmodule

// File: rtl/reg_writeback.sv
// Register file write front end: ALU/memory writeback arbitration into an
// ordered FIFO, plus read forwarding when REG_WRITEBACK_BYPASS_EN is defined.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              hazard,
    output logic [ADDR_W-1:0] pending
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(R_ZERO);

    logic [CW-1:0]                count;
    logic [CW-1:0]                free;
    logic [ADDR_W-1:0]            head_reg;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_reg;
    logic [DEPTH-1:0][DATA_W-1:0] entry_data;
    logic                         push_mem, push_alu;

    assign free      = CW'(free_slots(int'(count), DEPTH));
    assign mem_ready = (free != '0);
    assign alu_ready = mem_valid ? (free >= CW'(2)) : (free != '0);

    // Writes to the zero register are acknowledged but never take a slot.
    assign push_mem = mem_valid && mem_ready && (mem_reg != ZERO_REG);
    assign push_alu = alu_valid && alu_ready && (alu_reg != ZERO_REG);

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push0       (push_mem),
        .push0_reg   (mem_reg),
        .push0_data  (mem_data),
        .push1       (push_alu),
        .push1_reg   (alu_reg),
        .push1_data  (alu_data),
        .pop         (reg_write),
        .head_reg    (head_reg),
        .head_data   (head_data),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_reg   (entry_reg),
        .entry_data  (entry_data)
    );

    assign reg_write  = (count != '0);
    assign write_reg  = reg_write ? head_reg  : '0;
    assign write_data = reg_write ? head_data : '0;
    assign pending    = ADDR_W'(count);

`ifdef REG_WRITEBACK_BYPASS_EN
    // Higher slots are younger, so the last match in the scan wins.
    always_comb begin
        read_data1 = rf_data1;
        read_data2 = rf_data2;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_reg[i] == read_reg1)) read_data1 = entry_data[i];
            if (entry_valid[i] && (entry_reg[i] == read_reg2)) read_data2 = entry_data[i];
        end
        if (read_reg1 == ZERO_REG) read_data1 = '0;
        if (read_reg2 == ZERO_REG) read_data2 = '0;
    end

    assign hazard = 1'b0;
`else
    logic hit1, hit2;
    logic unused_entry_data;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 | (entry_valid[i] && (entry_reg[i] == read_reg1));
            hit2 = hit2 | (entry_valid[i] && (entry_reg[i] == read_reg2));
        end
    end

    assign hazard     = (hit1 && (read_reg1 != ZERO_REG)) || (hit2 && (read_reg2 != ZERO_REG));
    assign read_data1 = (read_reg1 == ZERO_REG) ? '0 : rf_data1;
    assign read_data2 = (read_reg2 == ZERO_REG) ? '0 : rf_data2;
    assign unused_entry_data = ^entry_data;
`endif

endmodule
